// File: rtl/part_inspect_ctrl.sv
// Teach-and-inspect sequencer: owns the part-memory control ports and the CCD
// read enable, records a reference part and tolerance-compares later parts to it.
module part_inspect_ctrl #(
    parameter int DATA_W   = 12,
    parameter int ADDR_W   = 10,
    parameter int END_CODE = 882,
    parameter int TOL      = 4,
    parameter int MAX_ERR  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              teach_req,
    input  logic              inspect_req,
    input  logic              abort,
    input  logic [DATA_W-1:0] ccd_data,
    input  logic              ccd_valid,
    output logic              ccd_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        err,
    output logic [ADDR_W:0]   ref_len,
    output logic [2:0]        state_dbg
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_T_WAIT  = 3'd1;
    localparam logic [2:0] ST_TEACH   = 3'd2;
    localparam logic [2:0] ST_I_WAIT  = 3'd3;
    localparam logic [2:0] ST_INSPECT = 3'd4;

    localparam logic [ADDR_W:0]   ZERO_V    = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   ONE_V     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   SAT_V     = {(ADDR_W+1){1'b1}};
    localparam logic [ADDR_W:0]   DEPTH_V   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LAST_V    = DEPTH_V - ONE_V;
    localparam logic [ADDR_W:0]   MAX_ERR_V = (ADDR_W+1)'(MAX_ERR);
    localparam logic [DATA_W-1:0] END_V     = DATA_W'(END_CODE);
    localparam logic [DATA_W-1:0] DZERO_V   = {DATA_W{1'b0}};
    localparam logic [DATA_W:0]   TOL_V     = (DATA_W+1)'(TOL);

    function automatic logic [DATA_W:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic signed [DATA_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d[DATA_W]) abs_diff = $unsigned(-d);
        else           abs_diff = $unsigned(d);
    endfunction

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
        sat_inc = (v == SAT_V) ? v : v + ONE_V;
    endfunction

    logic [2:0]        state_r, state_s;
    logic [ADDR_W:0]   index_r, index_s;
    logic [ADDR_W:0]   ref_len_r, ref_len_s;
    logic [ADDR_W:0]   mism_r, mism_s;
    logic [1:0]        err_r, err_s;
    logic              pass_r, pass_s;
    logic              done_r, done_s;
    logic              wren_r, wren_s;
    logic              rden_r, rden_s;
    logic              rd_p2_r, rd_p2_s;
    logic              end_pend_r, end_pend_s;
    logic              busy_r, ccd_enable_r;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic [DATA_W-1:0] held_r, held_s;
    logic              end_s, first_s, data_s, in_teach_s, in_insp_s;

    // Sample classification: END delimiter, first non-END sample, storable sample.
    always_comb begin
        end_s      = ccd_valid && (ccd_data == END_V);
        first_s    = ccd_valid && (ccd_data != END_V);
        data_s     = first_s && (ccd_data != DZERO_V);
        in_teach_s = (state_r == ST_TEACH)   || ((state_r == ST_T_WAIT) && first_s);
        in_insp_s  = (state_r == ST_INSPECT) || ((state_r == ST_I_WAIT) && first_s);
    end

    // Next-state and next-output computation.
    always_comb begin
        state_s    = state_r;
        index_s    = index_r;
        ref_len_s  = ref_len_r;
        mism_s     = mism_r;
        err_s      = err_r;
        pass_s     = pass_r;
        done_s     = 1'b0;
        wren_s     = 1'b0;
        rden_s     = 1'b0;
        rd_p2_s    = rden_r;
        end_pend_s = end_pend_r;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        held_s     = held_r;

        if (state_r == ST_IDLE) begin
            if (teach_req) begin
                state_s = ST_T_WAIT;
                err_s   = 2'b00;
                index_s = ZERO_V;
            end else if (inspect_req) begin
                pass_s = 1'b0;
                if (ref_len_r == ZERO_V) begin
                    err_s  = 2'b10;
                    done_s = 1'b1;
                end else begin
                    err_s      = 2'b00;
                    state_s    = ST_I_WAIT;
                    index_s    = ZERO_V;
                    mism_s     = ZERO_V;
                    end_pend_s = 1'b0;
                end
            end else begin
                state_s = ST_IDLE;
            end
        end else begin
            state_s = state_r;
        end

        if (in_teach_s) begin
            state_s = ST_TEACH;
            if (data_s) begin
                addr_s  = index_r[ADDR_W-1:0];
                wdata_s = ccd_data;
                wren_s  = 1'b1;
                index_s = index_r + ONE_V;
                if (index_r == LAST_V) begin
                    err_s     = 2'b01;
                    ref_len_s = DEPTH_V;
                    done_s    = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    ref_len_s = ref_len_r;
                end
            end else if (end_s) begin
                ref_len_s = index_r;
                done_s    = 1'b1;
                state_s   = ST_IDLE;
            end else begin
                index_s = index_r;
            end
        end else begin
            wren_s = 1'b0;
        end

        // Retire the compare for the read issued two cycles ago.
        if ((state_r == ST_INSPECT) && rd_p2_r) begin
            if (abs_diff(held_r, mem_q) > TOL_V) mism_s = sat_inc(mism_r);
            else                                  mism_s = mism_r;
        end else begin
            rd_p2_s = rden_r;
        end

        if (in_insp_s) begin
            state_s = ST_INSPECT;
            if (data_s) begin
                if (index_r < ref_len_r) begin
                    addr_s = index_r[ADDR_W-1:0];
                    rden_s = 1'b1;
                    held_s = ccd_data;
                end else begin
                    mism_s = sat_inc(mism_s);
                end
                index_s = sat_inc(index_r);
            end else if (end_s || end_pend_r) begin
                // The verdict waits until no read is still in flight.
                if (rden_r || rd_p2_r) begin
                    end_pend_s = 1'b1;
                end else begin
                    pass_s     = (index_r == ref_len_r) && (mism_r <= MAX_ERR_V);
                    err_s      = (index_r != ref_len_r) ? 2'b11 : 2'b00;
                    done_s     = 1'b1;
                    end_pend_s = 1'b0;
                    state_s    = ST_IDLE;
                end
            end else begin
                index_s = index_r;
            end
        end else begin
            rden_s = 1'b0;
        end

        if (abort) begin
            state_s    = ST_IDLE;
            ref_len_s  = ref_len_r;
            err_s      = err_r;
            pass_s     = pass_r;
            done_s     = 1'b0;
            wren_s     = 1'b0;
            rden_s     = 1'b0;
            rd_p2_s    = 1'b0;
            end_pend_s = 1'b0;
        end else begin
            end_pend_s = end_pend_s;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            index_r      <= ZERO_V;
            ref_len_r    <= ZERO_V;
            mism_r       <= ZERO_V;
            err_r        <= 2'b00;
            pass_r       <= 1'b0;
            done_r       <= 1'b0;
            wren_r       <= 1'b0;
            rden_r       <= 1'b0;
            rd_p2_r      <= 1'b0;
            end_pend_r   <= 1'b0;
            busy_r       <= 1'b0;
            ccd_enable_r <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= DZERO_V;
            held_r       <= DZERO_V;
        end else begin
            state_r      <= state_s;
            index_r      <= index_s;
            ref_len_r    <= ref_len_s;
            mism_r       <= mism_s;
            err_r        <= err_s;
            pass_r       <= pass_s;
            done_r       <= done_s;
            wren_r       <= wren_s;
            rden_r       <= rden_s;
            rd_p2_r      <= rd_p2_s;
            end_pend_r   <= end_pend_s;
            busy_r       <= (state_s != ST_IDLE);
            ccd_enable_r <= (state_s != ST_IDLE);
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            held_r       <= held_s;
        end
    end

    assign ccd_enable = ccd_enable_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = wdata_r;
    assign mem_wren   = wren_r;
    assign mem_rden   = rden_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign err        = err_r;
    assign ref_len    = ref_len_r;
    assign state_dbg  = state_r;

endmodule

// File: tb/tb_part_inspect_ctrl.sv
// Directed bench for part_inspect_ctrl with a small part-memory model and
// write/read/done monitors.
module tb_part_inspect_ctrl;

    localparam int DW = 12;
    localparam int AW = 3;
    localparam logic [DW-1:0] END_S = 12'd882;

    logic          clk = 1'b0;
    logic          rst_n, teach_req, inspect_req, abort, ccd_valid;
    logic [DW-1:0] ccd_data;
    logic          ccd_enable, mem_wren, mem_rden, busy, done, pass;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_q = 12'd0;
    logic [1:0]    err;
    logic [AW:0]   ref_len;
    logic [2:0]    state_dbg;

    logic [DW-1:0] mem [0:7];
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    logic [AW-1:0] rd_addr_q [$];
    int done_cnt = 0;
    int en_cnt   = 0;
    int checks   = 0;
    int errors   = 0;
    int d0;

    always #10 clk = ~clk;

    part_inspect_ctrl #(.DATA_W(DW), .ADDR_W(AW), .END_CODE(882), .TOL(4), .MAX_ERR(0)) dut (
        .clk(clk), .rst_n(rst_n), .teach_req(teach_req), .inspect_req(inspect_req),
        .abort(abort), .ccd_data(ccd_data), .ccd_valid(ccd_valid), .ccd_enable(ccd_enable),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rden(mem_rden),
        .mem_q(mem_q), .busy(busy), .done(done), .pass(pass), .err(err),
        .ref_len(ref_len), .state_dbg(state_dbg)
    );

    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        if (mem_rden) mem_q <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wren) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end
            if (mem_rden) rd_addr_q.push_back(mem_addr);
            if (done) done_cnt++;
            if (ccd_enable) en_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] s);
        ccd_data  = s;
        ccd_valid = 1'b1;
        tick();
        ccd_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic pulse_teach();
        teach_req = 1'b1;
        tick();
        teach_req = 1'b0;
    endtask

    task automatic pulse_inspect();
        inspect_req = 1'b1;
        tick();
        inspect_req = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; teach_req = 1'b0; inspect_req = 1'b0; abort = 1'b0;
        ccd_valid = 1'b0; ccd_data = 12'd0;
        repeat (3) tick();
        check("reset_outputs", {ccd_enable, mem_addr, mem_wdata, mem_wren, mem_rden,
                                busy, done, pass, err, ref_len, state_dbg}, 32'd0);
        rst_n = 1'b1;
        tick();

        // No reference stored yet
        pulse_inspect();
        check("noref_done", done, 1);
        check("noref_err", err, 2);
        check("noref_busy", busy, 0);
        tick();
        check("noref_done_single", done, 0);
        check("noref_no_enable", en_cnt, 0);

        // Simultaneous requests: teach wins, then abort
        teach_req = 1'b1; inspect_req = 1'b1;
        tick();
        teach_req = 1'b0; inspect_req = 1'b0;
        check("collide_state", state_dbg, 1);
        check("collide_enable", ccd_enable, 1);
        check("collide_err_cleared", err, 0);
        d0 = done_cnt;
        pulse_abort();
        check("collide_abort_state", state_dbg, 0);
        check("collide_abort_enable", ccd_enable, 0);
        check("collide_abort_nodone", done_cnt, d0);

        // Teach END,END,100,0,200,300,END
        wr_addr_q.delete(); wr_data_q.delete();
        d0 = done_cnt;
        pulse_teach();
        send(END_S); send(END_S); send(12'd100); send(12'd0);
        send(12'd200); send(12'd300); send(END_S);
        check("teach_done", done_cnt, d0 + 1);
        check("teach_ref_len", ref_len, 3);
        check("teach_nwrites", wr_addr_q.size(), 3);
        check("teach_w0", {wr_addr_q[0], wr_data_q[0]}, {3'd0, 12'd100});
        check("teach_w1", {wr_addr_q[1], wr_data_q[1]}, {3'd1, 12'd200});
        check("teach_w2", {wr_addr_q[2], wr_data_q[2]}, {3'd2, 12'd300});
        check("teach_idle", {busy, ccd_enable, state_dbg, err}, 0);

        // Inspect within tolerance
        rd_addr_q.delete();
        d0 = done_cnt;
        pulse_inspect();
        send(END_S); send(12'd103); send(12'd198); send(12'd300); send(END_S);
        check("insp_pass", pass, 1);
        check("insp_err", err, 0);
        check("insp_done", done_cnt, d0 + 1);
        check("insp_nreads", rd_addr_q.size(), 3);
        check("insp_raddrs", {rd_addr_q[0], rd_addr_q[1], rd_addr_q[2]}, {3'd0, 3'd1, 3'd2});

        // Inspect with one sample out of tolerance (210 vs 200)
        pulse_inspect();
        check("tol_pass_cleared", pass, 0);
        send(12'd100); send(12'd210); send(12'd300); send(END_S);
        check("tol_pass", pass, 0);
        check("tol_err", err, 0);

        // Good part again so that pass is high before the mismatch run
        pulse_inspect();
        send(12'd101); send(12'd200); send(12'd296); send(END_S);
        check("edge_tol_pass", pass, 1);

        // Length mismatch
        d0 = done_cnt;
        pulse_inspect();
        send(12'd100); send(12'd200); send(END_S);
        check("len_pass", pass, 0);
        check("len_err", err, 3);
        check("len_done", done_cnt, d0 + 1);

        // Overflow: 9 nonzero samples into an 8-deep memory
        wr_addr_q.delete(); wr_data_q.delete();
        d0 = done_cnt;
        pulse_teach();
        for (int i = 1; i <= 9; i++) send(12'(i * 10 + 1));
        check("ovf_nwrites", wr_addr_q.size(), 8);
        check("ovf_last", {wr_addr_q[7], wr_data_q[7]}, {3'd7, 12'd81});
        check("ovf_err", err, 1);
        check("ovf_ref_len", ref_len, 8);
        check("ovf_done", done_cnt, d0 + 1);
        check("ovf_idle", state_dbg, 0);

        // Abort mid-TEACH keeps the previous reference length
        d0 = done_cnt;
        pulse_teach();
        send(12'd5); send(12'd6);
        check("abort_in_teach", state_dbg, 2);
        pulse_abort();
        check("abort_state", state_dbg, 0);
        check("abort_outputs", {ccd_enable, busy, mem_wren, mem_rden}, 0);
        check("abort_ref_len", ref_len, 8);
        check("abort_nodone", done_cnt, d0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
